// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller.
// The controller FSM states and a program-select range helper.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        RC_IDLE,
        RC_RST,
        RC_LOAD,
        RC_RUN,
        RC_DONE
    } run_state_e;

    localparam int RC_MAX_PROGS = 8;

    function automatic logic sel_in_range(input int sel, input int num_progs);
        return (sel < num_progs);
    endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Sequenced run controller: req edge -> core reset -> start-PC load -> run -> done/timeout -> ack.
// Every output is a flop computed from the next state, so nothing passes combinationally.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int                   T         = 10,
    parameter int                   NUM_PROGS = 3,
    parameter int                   PSW       = 2,
    parameter logic [NUM_PROGS*T-1:0] START_PC = '0,
    parameter int                   RST_CYC   = 2,
    parameter int                   CYC_W     = 16,
    parameter int                   TIMEOUT   = 0,
    parameter int                   ACK_PULSE = 0
) (
    input  logic             clk,
    input  logic             init,
    input  logic             req,
    input  logic [PSW-1:0]   prog_sel,
    input  logic             core_done,
    output logic             core_reset,
    output logic             core_load_pc,
    output logic [T-1:0]     core_start_pc,
    output logic             core_run,
    output logic             ack,
    output logic             busy,
    output logic             timeout,
    output logic             bad_sel,
    output logic [CYC_W-1:0] cycle_count
);

    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    run_state_e  state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [T-1:0]  pc_q, pc_d;
    logic          req_q;
    logic          core_reset_q, core_reset_d;
    logic          load_q, load_d;
    logic          run_q, run_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic          bad_sel_q, bad_sel_d;
    logic          start, sel_ok, cnt_clr, cnt_en, wdog_hit;
    logic [CYC_W-1:0] cnt;

    assign start    = req & ~req_q & (state_q == RC_IDLE);
    assign sel_ok   = sel_in_range(int'(prog_sel), NUM_PROGS);
    assign cnt_en   = (state_q == RC_RUN);
    assign wdog_hit = (TIMEOUT != 0) && (32'(cnt) == 32'(TIMEOUT - 1));

    sat_counter #(.W(CYC_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (init),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt)
    );

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        pc_d      = pc_q;
        timeout_d = timeout_q;
        bad_sel_d = 1'b0;
        cnt_clr   = 1'b0;
        case (state_q)
            RC_IDLE: begin
                if (start) begin
                    if (sel_ok) begin
                        for (int i = 0; i < NUM_PROGS; i++)
                            if (int'(prog_sel) == i)
                                pc_d = START_PC[i*T +: T];
                        timeout_d = 1'b0;
                        cnt_clr   = 1'b1;
                        rst_cnt_d = RW'(RST_CYC - 1);
                        state_d   = RC_RST;
                    end else begin
                        bad_sel_d = 1'b1;
                    end
                end
            end
            RC_RST: begin
                if (rst_cnt_q == '0)
                    state_d = RC_LOAD;
                else
                    rst_cnt_d = rst_cnt_q - 1'b1;
            end
            RC_LOAD: state_d = RC_RUN;
            RC_RUN: begin
                // done takes priority over a watchdog expiry in the same cycle
                if (core_done) begin
                    state_d = RC_DONE;
                end else if (wdog_hit) begin
                    timeout_d = 1'b1;
                    state_d   = RC_DONE;
                end
            end
            RC_DONE: begin
                if ((ACK_PULSE != 0) || !req)
                    state_d = RC_IDLE;
            end
            default: state_d = RC_IDLE;
        endcase

        core_reset_d = (state_d == RC_RST);
        load_d       = (state_d == RC_LOAD);
        run_d        = (state_d == RC_RUN);
        ack_d        = (state_d == RC_DONE);
        busy_d       = (state_d == RC_RST) || (state_d == RC_LOAD) || (state_d == RC_RUN);
    end

    always_ff @(posedge clk) begin
        // req_q tracks req even under init so a req held through init is not seen as an edge
        req_q <= req;
        if (init) begin
            state_q      <= RC_IDLE;
            rst_cnt_q    <= '0;
            pc_q         <= '0;
            core_reset_q <= 1'b0;
            load_q       <= 1'b0;
            run_q        <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            bad_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            pc_q         <= pc_d;
            core_reset_q <= core_reset_d;
            load_q       <= load_d;
            run_q        <= run_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            bad_sel_q    <= bad_sel_d;
        end
    end

    assign core_reset    = core_reset_q;
    assign core_load_pc  = load_q;
    assign core_start_pc = pc_q;
    assign core_run      = run_q;
    assign ack           = ack_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;
    assign bad_sel       = bad_sel_q;
    assign cycle_count   = cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a cycle table for the basic start/run/ack flow plus
// hand sequences for watchdog, init abort and the two ack modes.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        init, req, core_done;
    logic [1:0]  prog_sel;

    logic        a_core_reset, a_core_load_pc, a_core_run, a_ack, a_busy, a_timeout, a_bad_sel;
    logic [9:0]  a_pc;
    logic [15:0] a_cnt;
    logic        b_core_reset, b_core_load_pc, b_core_run, b_ack, b_busy, b_timeout, b_bad_sel;
    logic [9:0]  b_pc;
    logic [15:0] b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .T(10), .NUM_PROGS(3), .PSW(2), .START_PC({10'd200, 10'd100, 10'd0}),
        .RST_CYC(2), .CYC_W(16), .TIMEOUT(20), .ACK_PULSE(0)
    ) dut_a (
        .clk(clk), .init(init), .req(req), .prog_sel(prog_sel), .core_done(core_done),
        .core_reset(a_core_reset), .core_load_pc(a_core_load_pc), .core_start_pc(a_pc),
        .core_run(a_core_run), .ack(a_ack), .busy(a_busy), .timeout(a_timeout),
        .bad_sel(a_bad_sel), .cycle_count(a_cnt)
    );

    run_ctrl #(
        .T(10), .NUM_PROGS(3), .PSW(2), .START_PC({10'd200, 10'd100, 10'd0}),
        .RST_CYC(2), .CYC_W(16), .TIMEOUT(20), .ACK_PULSE(1)
    ) dut_b (
        .clk(clk), .init(init), .req(req), .prog_sel(prog_sel), .core_done(core_done),
        .core_reset(b_core_reset), .core_load_pc(b_core_load_pc), .core_start_pc(b_pc),
        .core_run(b_core_run), .ack(b_ack), .busy(b_busy), .timeout(b_timeout),
        .bad_sel(b_bad_sel), .cycle_count(b_cnt)
    );

    // flag order: {core_reset, core_load_pc, core_run, ack, busy, timeout, bad_sel}
    localparam logic [6:0] F_RST  = 7'b1000000;
    localparam logic [6:0] F_LD   = 7'b0100000;
    localparam logic [6:0] F_RUN  = 7'b0010000;
    localparam logic [6:0] F_ACK  = 7'b0001000;
    localparam logic [6:0] F_BUSY = 7'b0000100;
    localparam logic [6:0] F_BAD  = 7'b0000001;

    typedef struct {
        logic        init;
        logic        req;
        logic [1:0]  sel;
        logic        done;
        logic [6:0]  flags;
        logic [9:0]  pc;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic i, input logic r, input logic [1:0] s, input logic d,
                                input logic [6:0] f, input logic [9:0] p, input logic [15:0] c);
        vec_t v;
        v.init = i; v.req = r; v.sel = s; v.done = d; v.flags = f; v.pc = p; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int runs, n;
        logic seen_ack, seen_rst;

        init = 1'b1; req = 1'b1; prog_sel = 2'd0; core_done = 1'b0;

        // init held with req high, then held req must not start
        vecs[0] = mk(1, 1, 0, 0, 7'd0, 10'd0, 16'd0);
        vecs[1] = mk(1, 1, 0, 0, 7'd0, 10'd0, 16'd0);
        vecs[2] = mk(0, 1, 0, 0, 7'd0, 10'd0, 16'd0);
        vecs[3] = mk(0, 0, 1, 0, 7'd0, 10'd0, 16'd0);
        // program 1, done seen on 7th run cycle
        vecs[4] = mk(0, 1, 1, 0, F_RST | F_BUSY, 10'd100, 16'd0);
        vecs[5] = mk(0, 1, 1, 0, F_RST | F_BUSY, 10'd100, 16'd0);
        vecs[6] = mk(0, 1, 1, 0, F_LD  | F_BUSY, 10'd100, 16'd0);
        vecs[7] = mk(0, 1, 1, 0, F_RUN | F_BUSY, 10'd100, 16'd0);
        for (int k = 8; k < 14; k++)
            vecs[k] = mk(0, 1, 1, 0, F_RUN | F_BUSY, 10'd100, 16'(k - 7));
        vecs[14] = mk(0, 1, 1, 1, F_ACK, 10'd100, 16'd7);
        vecs[15] = mk(0, 1, 1, 0, F_ACK, 10'd100, 16'd7);
        vecs[16] = mk(0, 0, 1, 0, 7'd0,  10'd100, 16'd7);
        // out-of-range program select
        vecs[17] = mk(0, 1, 3, 0, F_BAD, 10'd100, 16'd7);
        vecs[18] = mk(0, 1, 3, 0, 7'd0,  10'd100, 16'd7);
        vecs[19] = mk(0, 0, 3, 0, 7'd0,  10'd100, 16'd7);

        for (int i = 0; i < 20; i++) begin
            init = vecs[i].init; req = vecs[i].req; prog_sel = vecs[i].sel; core_done = vecs[i].done;
            tick();
            chk($sformatf("row%0d flags", i),
                32'({a_core_reset, a_core_load_pc, a_core_run, a_ack, a_busy, a_timeout, a_bad_sel}),
                32'(vecs[i].flags));
            chk($sformatf("row%0d start_pc", i), 32'(a_pc), 32'(vecs[i].pc));
            chk($sformatf("row%0d cycle_count", i), 32'(a_cnt), 32'(vecs[i].cnt));
        end

        // watchdog: program 2, done never arrives
        req = 1'b1; prog_sel = 2'd2;
        tick();
        chk("wd start_pc", 32'(a_pc), 32'd200);
        repeat (3) tick();
        runs = 0; n = 0;
        while (!a_ack && n < 100) begin
            if (a_core_run) runs++;
            tick();
            n++;
        end
        chk("wd run cycles", 32'(runs), 32'd20);
        chk("wd timeout", 32'(a_timeout), 32'd1);
        chk("wd ack", 32'(a_ack), 32'd1);
        chk("wd busy", 32'(a_busy), 32'd0);
        chk("wd cycle_count", 32'(a_cnt), 32'd20);
        req = 1'b0;
        tick();
        chk("wd ack clear", 32'(a_ack), 32'd0);
        chk("wd timeout held", 32'(a_timeout), 32'd1);

        // done on the 20th run cycle beats the watchdog
        req = 1'b1; prog_sel = 2'd0;
        tick();
        chk("race timeout cleared", 32'(a_timeout), 32'd0);
        chk("race start_pc", 32'(a_pc), 32'd0);
        repeat (3) tick();
        repeat (19) tick();
        chk("race still running", 32'(a_core_run), 32'd1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("race timeout", 32'(a_timeout), 32'd0);
        chk("race ack", 32'(a_ack), 32'd1);
        chk("race cycle_count", 32'(a_cnt), 32'd20);
        req = 1'b0;
        tick();

        // init mid-run aborts without ack
        req = 1'b1; prog_sel = 2'd1;
        repeat (4) tick();
        repeat (3) tick();
        chk("abort running", 32'(a_core_run), 32'd1);
        init = 1'b1;
        tick();
        chk("abort core_run", 32'(a_core_run), 32'd0);
        chk("abort busy", 32'(a_busy), 32'd0);
        init = 1'b0; req = 1'b0;
        seen_ack = 1'b0; seen_rst = 1'b0;
        repeat (5) begin
            tick();
            seen_ack |= a_ack;
            seen_rst |= a_core_reset;
        end
        chk("abort no ack", 32'(seen_ack), 32'd0);
        chk("abort no restart", 32'(seen_rst), 32'd0);

        // level ack (dut_a) vs pulse ack (dut_b) with req held high
        req = 1'b1; prog_sel = 2'd1;
        repeat (4) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("lvl ack first", 32'(a_ack), 32'd1);
        chk("pulse ack first", 32'(b_ack), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("lvl ack hold%0d", k), 32'(a_ack), 32'd1);
            chk($sformatf("pulse ack low%0d", k), 32'(b_ack), 32'd0);
            chk($sformatf("pulse no restart%0d", k), 32'({b_busy, b_core_reset}), 32'd0);
        end
        req = 1'b0;
        tick();
        chk("lvl ack clear", 32'(a_ack), 32'd0);
        req = 1'b1;
        tick();
        chk("pulse restart busy", 32'(b_busy), 32'd1);
        chk("pulse restart reset", 32'(b_core_reset), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
